// File: rtl/z80_bus_pkg.sv
// Shared types and constants for the Z80 pin-bus to SoC req/ack bridge.
package z80_bus_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam logic [7:0]  DATA_IDLE = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } bus_state_e;

   // Latched SoC-side command, presented on the b_* outputs while a request is open
   typedef struct packed {
      logic              we;
      logic              io;
      logic [ADDR_W-1:0] addr;
      logic [7:0]        wdata;
   } bus_cmd_t;

   function automatic int unsigned cnt_width(input int unsigned cyc);
      return $clog2(cyc + 1);
   endfunction

endpackage

// File: rtl/z80_strobe_decode.sv
// Decodes Z80 control pins into an active-cycle flag, interrupt acknowledge and cycle qualifiers.
module z80_strobe_decode (
   input  logic z_mreq_n_i,
   input  logic z_iorq_n_i,
   input  logic z_rd_n_i,
   input  logic z_wr_n_i,
   input  logic z_m1_n_i,
   output logic act_o,
   output logic intack_o,
   output logic io_o,
   output logic wr_o
);

   assign act_o    = (~z_rd_n_i | ~z_wr_n_i) & (~z_mreq_n_i | ~z_iorq_n_i);
   assign intack_o = ~z_m1_n_i & ~z_iorq_n_i;
   assign io_o     = ~z_iorq_n_i;
   assign wr_o     = ~z_wr_n_i;

endmodule

// File: rtl/z80_bus_bridge.sv
// Z80 pin bus to single-outstanding req/ack SoC bus bridge with CPU wait stretching.
// Optional slave ack timeout enabled by defining Z80_BRIDGE_TIMEOUT_EN.
module z80_bus_bridge
   import z80_bus_pkg::*;
#(
   parameter int unsigned IO_ADDR_W   = 8,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] z_a,
   input  logic [7:0]  z_dout,
   input  logic        z_mreq_n,
   input  logic        z_iorq_n,
   input  logic        z_rd_n,
   input  logic        z_wr_n,
   input  logic        z_m1_n,
   output logic [7:0]  z_din,
   output logic        z_wait_n,
   input  logic [7:0]  int_vec,
   output logic        b_req,
   output logic        b_we,
   output logic        b_io,
   output logic [15:0] b_addr,
   output logic [7:0]  b_wdata,
   input  logic        b_ack,
   input  logic [7:0]  b_rdata,
   output logic        timeout_evt
);

   if (IO_ADDR_W < 1 || IO_ADDR_W > ADDR_W || TIMEOUT_CYC < 1) begin : g_param_chk
      $error("z80_bus_bridge: IO_ADDR_W must be 1..16 and TIMEOUT_CYC at least 1");
   end

   logic act, intack, is_io, is_wr;

   z80_strobe_decode u_decode (
      .z_mreq_n_i (z_mreq_n),
      .z_iorq_n_i (z_iorq_n),
      .z_rd_n_i   (z_rd_n),
      .z_wr_n_i   (z_wr_n),
      .z_m1_n_i   (z_m1_n),
      .act_o      (act),
      .intack_o   (intack),
      .io_o       (is_io),
      .wr_o       (is_wr)
   );

   bus_state_e state_q, state_d;
   logic       req_q, req_d;
   bus_cmd_t   cmd_q, cmd_d;
   logic [7:0] din_q, din_d;

`ifdef Z80_BRIDGE_TIMEOUT_EN
   localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYC);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tevt_q, tevt_d;
`endif

   // Next-state and next-output logic
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      cmd_d   = cmd_q;
      din_d   = din_q;
`ifdef Z80_BRIDGE_TIMEOUT_EN
      cnt_d   = cnt_q;
      tevt_d  = 1'b0;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (intack) begin
               din_d   = int_vec;
               state_d = ST_DONE;
            end else if (act) begin
               cmd_d.we    = is_wr;
               cmd_d.io    = is_io;
               cmd_d.addr  = is_io ? ADDR_W'(z_a[IO_ADDR_W-1:0]) : z_a;
               cmd_d.wdata = z_dout;
               req_d       = 1'b1;
               state_d     = ST_REQ;
`ifdef Z80_BRIDGE_TIMEOUT_EN
               cnt_d       = '0;
`endif
            end
         end
         ST_REQ: begin
            // An aborted CPU cycle still drains the slave ack, but its data is dropped
            if (b_ack) begin
               req_d = 1'b0;
               if (!act) begin
                  state_d = ST_IDLE;
               end else begin
                  if (!cmd_q.we) din_d = b_rdata;
                  state_d = ST_DONE;
               end
            end
`ifdef Z80_BRIDGE_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               req_d   = 1'b0;
               din_d   = DATA_IDLE;
               tevt_d  = 1'b1;
               state_d = act ? ST_DONE : ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         ST_DONE: begin
            if (!act && !intack) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         req_q   <= 1'b0;
         cmd_q   <= '0;
         din_q   <= DATA_IDLE;
`ifdef Z80_BRIDGE_TIMEOUT_EN
         cnt_q   <= '0;
         tevt_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         cmd_q   <= cmd_d;
         din_q   <= din_d;
`ifdef Z80_BRIDGE_TIMEOUT_EN
         cnt_q   <= cnt_d;
         tevt_q  <= tevt_d;
`endif
      end
   end

   // Wait goes low in the same cycle the strobe appears so the CPU never samples early
   assign z_wait_n = ~(reset_n & (act | intack) & ((state_q == ST_IDLE) | (state_q == ST_REQ)));

   assign z_din   = din_q;
   assign b_req   = req_q;
   assign b_we    = cmd_q.we;
   assign b_io    = cmd_q.io;
   assign b_addr  = cmd_q.addr;
   assign b_wdata = cmd_q.wdata;

`ifdef Z80_BRIDGE_TIMEOUT_EN
   assign timeout_evt = tevt_q;
`else
   assign timeout_evt = 1'b0;
`endif

endmodule
